reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 171 +++++++++++++++++
 tb/tb_reg_dump_reader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
// Walks an inclusive, possibly wrapping, range of register-file indices.
// Each word is read through a combinational debug port, captured, and then
// offered downstream with a valid/ready handshake.
// Flow: IDLE -> FETCH -> SEND -> (FETCH ... ) -> DONE -> IDLE.
// A captured word is a snapshot. Later register-file writes never disturb a
// word that is already held for the consumer.

module reg_dump_reader #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [IDX_W-1:0]  first_idx,
   input  logic [IDX_W-1:0]  last_idx,
   output logic [IDX_W-1:0]  rf_idx,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   state_t             state_r;
   state_t             state_s;
   logic [IDX_W-1:0]   ptr_r;
   logic [IDX_W-1:0]   ptr_s;
   logic [IDX_W-1:0]   first_r;
   logic [IDX_W-1:0]   first_s;
   logic [IDX_W-1:0]   last_r;
   logic [IDX_W-1:0]   last_s;
   logic               capture_s;

   logic [DATA_W-1:0]  out_data_r;
   logic [IDX_W-1:0]   out_idx_r;
   logic               out_last_r;
   logic               out_valid_r;
   logic               busy_r;
   logic               done_r;

   // The pointer is cleared whenever the block goes idle. As a result, the
   // read index can come straight from a register: it is 0 in IDLE and
   // follows the pointer during FETCH.
   assign rf_idx    = ptr_r;
   assign out_data  = out_data_r;
   assign out_idx   = out_idx_r;
   assign out_last  = out_last_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign done      = done_r;

   // Next-state, pointer and range-latch decisions.
   always_comb begin
      state_s   = state_r;
      ptr_s     = ptr_r;
      first_s   = first_r;
      last_s    = last_r;
      capture_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               first_s = first_idx;
               last_s  = last_idx;
               ptr_s   = first_idx;
               state_s = FETCH;
            end else begin
               ptr_s   = IDX_ZERO;
               state_s = IDLE;
            end
         end
         FETCH: begin
            if (abort) begin
               ptr_s   = IDX_ZERO;
               state_s = IDLE;
            end else begin
               capture_s = 1'b1;
               state_s   = SEND;
            end
         end
         SEND: begin
            // Abort wins over a handshake in the same cycle. That word
            // counts as not delivered.
            if (abort) begin
               ptr_s   = IDX_ZERO;
               state_s = IDLE;
            end else if (out_ready) begin
               if (out_last_r) begin
                  state_s = DONE;
               end else begin
                  ptr_s   = ptr_r + IDX_ONE;
                  state_s = FETCH;
               end
            end else begin
               state_s = SEND;
            end
         end
         DONE: begin
            ptr_s   = IDX_ZERO;
            state_s = IDLE;
         end
         default: begin
            ptr_s   = IDX_ZERO;
            state_s = IDLE;
         end
      endcase
   end

   // Control state: FSM, pointer and latched range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         ptr_r   <= IDX_ZERO;
         first_r <= IDX_ZERO;
         last_r  <= IDX_ZERO;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
         first_r <= first_s;
         last_r  <= last_s;
      end
   end

   // Snapshot of the fetched word. It is held until the next FETCH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_r <= DATA_ZERO;
         out_idx_r  <= IDX_ZERO;
         out_last_r <= 1'b0;
      end else if (capture_s) begin
         out_data_r <= rf_data;
         out_idx_r  <= ptr_r;
         out_last_r <= (ptr_r == last_r);
      end else begin
         out_data_r <= out_data_r;
         out_idx_r  <= out_idx_r;
         out_last_r <= out_last_r;
      end
   end

   // Status outputs. They are registered from the next state, so each one
   // lines up with the state it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         out_valid_r <= (state_s == SEND);
         busy_r      <= (state_s == FETCH) || (state_s == SEND);
         done_r      <= (state_s == DONE);
      end
   end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader.
// A small scoreboard model predicts the outputs for each cycle. The model
// works from word lists and handshake rules. Hand-computed literal checks
// pin the model down for the required scenarios.

module tb_reg_dump_reader;

   localparam int NREG = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  first_idx = 4'd0;
   logic [3:0]  last_idx = 4'd0;
   logic [3:0]  rf_idx;
   logic [15:0] rf_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic [3:0]  out_idx;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [15:0] rf [NREG];

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   int          q[$];
   bit          m_busy = 1'b0;
   bit          m_valid = 1'b0;
   bit          m_done = 1'b0;
   logic [15:0] m_snap = 16'd0;

   // words actually handed over
   logic [15:0] got_data[$];
   int          got_idx[$];
   bit          got_last[$];

   reg_dump_reader #(.DATA_W(16), .IDX_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .first_idx(first_idx), .last_idx(last_idx),
      .rf_idx(rf_idx), .rf_data(rf_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .busy(busy), .done(done)
   );

   assign rf_data = rf[rf_idx];

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare the outputs with the model, then advance the model.
   // Inputs change at posedge+2, so at negedge they hold the values the
   // next edge will sample.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         m_busy  = 1'b0;
         m_valid = 1'b0;
         m_done  = 1'b0;
      end else begin
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         if (!m_busy && !m_done) chk("rf_idx_idle", 32'(rf_idx), 32'd0);
         if (m_busy && !m_valid) chk("rf_idx_fetch", 32'(rf_idx), q[0]);
         if (m_valid) begin
            chk("out_idx", 32'(out_idx), q[0]);
            chk("out_last", 32'(out_last), (q.size() == 1) ? 32'd1 : 32'd0);
            chk("out_data", 32'(out_data), 32'(m_snap));
         end
         if (m_done) begin
            m_done = 1'b0;
         end else if (!m_busy) begin
            if (start) begin
               int n;
               n = ((int'(last_idx) - int'(first_idx) + NREG) % NREG) + 1;
               for (int k = 0; k < n; k++) q.push_back((int'(first_idx) + k) % NREG);
               m_busy = 1'b1;
            end
         end else if (!m_valid) begin
            if (abort) begin
               q.delete();
               m_busy = 1'b0;
            end else begin
               m_snap  = rf[q[0]];
               m_valid = 1'b1;
            end
         end else begin
            if (abort) begin
               q.delete();
               m_busy  = 1'b0;
               m_valid = 1'b0;
            end else if (out_ready) begin
               got_data.push_back(out_data);
               got_idx.push_back(int'(out_idx));
               got_last.push_back(out_last);
               void'(q.pop_front());
               m_valid = 1'b0;
               if (q.size() == 0) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_got();
      got_data.delete();
      got_idx.delete();
      got_last.delete();
   endtask

   task automatic pulse_start(input logic [3:0] f, input logic [3:0] l);
      first_idx = f;
      last_idx  = l;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk({nm, "_done_seen"}, 32'(seen), 32'd1);
      tick();
   endtask

   initial begin
      for (int i = 0; i < NREG; i++) rf[i] = 16'h1000 + 16'(i);
      #3;
      // reset state
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rf_idx", 32'(rf_idx), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // basic dump 2..5, with latency checks
      clear_got();
      pulse_start(4'd2, 4'd5);
      chk("lat_fetch_valid", 32'(out_valid), 32'd0);
      chk("lat_fetch_rf_idx", 32'(rf_idx), 32'd2);
      tick();
      chk("lat_send_valid", 32'(out_valid), 32'd1);
      chk("lat_send_data", 32'(out_data), 32'h1002);
      wait_done("basic");
      begin
         int          e_idx[4]  = '{2, 3, 4, 5};
         logic [15:0] e_dat[4]  = '{16'h1002, 16'h1003, 16'h1004, 16'h1005};
         bit          e_last[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
         chk("basic_count", got_idx.size(), 32'd4);
         for (int k = 0; k < 4 && k < got_idx.size(); k++) begin
            chk("basic_idx", got_idx[k], e_idx[k]);
            chk("basic_data", 32'(got_data[k]), 32'(e_dat[k]));
            chk("basic_last", 32'(got_last[k]), 32'(e_last[k]));
         end
      end

      // wrap-around 14..1
      clear_got();
      pulse_start(4'd14, 4'd1);
      wait_done("wrap");
      begin
         int e_idx[4] = '{14, 15, 0, 1};
         chk("wrap_count", got_idx.size(), 32'd4);
         for (int k = 0; k < 4 && k < got_idx.size(); k++) chk("wrap_idx", got_idx[k], e_idx[k]);
      end

      // single word 7..7
      clear_got();
      pulse_start(4'd7, 4'd7);
      wait_done("single");
      chk("single_count", got_idx.size(), 32'd1);
      if (got_idx.size() > 0) begin
         chk("single_idx", got_idx[0], 32'd7);
         chk("single_last", 32'(got_last[0]), 32'd1);
      end

      // backpressure with register write during stall
      clear_got();
      out_ready = 1'b0;
      pulse_start(4'd3, 4'd4);
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 1) rf[3] = 16'hBEEF;
         chk("bp_stall_data", 32'(out_data), 32'h1003);
         chk("bp_stall_idx", 32'(out_idx), 32'd3);
      end
      out_ready = 1'b1;
      wait_done("bp");
      chk("bp_count", got_idx.size(), 32'd2);
      if (got_data.size() > 0) chk("bp_word0", 32'(got_data[0]), 32'h1003);
      rf[3] = 16'h1003;

      // abort on the 2nd word of 0..15, same cycle as ready
      clear_got();
      pulse_start(4'd0, 4'd15);
      begin
         bit found = 1'b0;
         for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1 && out_idx === 4'd1) begin
               found = 1'b1;
               break;
            end
            tick();
         end
         chk("abort_reach_word1", 32'(found), 32'd1);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("abort_count", got_idx.size(), 32'd1);
      clear_got();
      pulse_start(4'd5, 4'd6);
      wait_done("post_abort");
      chk("post_abort_count", got_idx.size(), 32'd2);

      // async reset mid-FETCH
      pulse_start(4'd0, 4'd3);
      #1 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rf_idx", 32'(rf_idx), 32'd0);
      chk("arst_data", 32'(out_data), 32'd0);
      chk("arst_idx", 32'(out_idx), 32'd0);
      chk("arst_last", 32'(out_last), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("arst_stays_idle", 32'(busy), 32'd0);

      // start while busy is ignored
      clear_got();
      pulse_start(4'd4, 4'd6);
      tick();
      first_idx = 4'd0;
      last_idx  = 4'd15;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      wait_done("ignore_start");
      begin
         int e_idx[3] = '{4, 5, 6};
         chk("ignore_count", got_idx.size(), 32'd3);
         for (int k = 0; k < 3 && k < got_idx.size(); k++) chk("ignore_idx", got_idx[k], e_idx[k]);
      end

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
